mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle control unit for the 32-bit MIPS-subset core. Sequences each instruction through fetch, decode, execute, memory and write-back states. Drives the datapath mux selects and write enables, plus the 3-bit ALU operation code consumed directly by the ALU. Sits upstream of the ALU: it decides what the ALU computes each cycle and whether the PC takes the ALU's zero flag.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; stable from the cycle after FETCH until the instruction completes
- funct  in  6  IR[5:0]; same stability as opcode
- zero  in  1  ALU Zero flag, same cycle
- pc_en  out  1  PC load enable: pc_write | (branch & zero)
- pc_src  out  2  PC source: 00 ALU result, 01 ALUOut register, 10 jump target
- iord  out  1  memory address: 0 PC, 1 ALUOut
- mem_write  out  1  data memory write
- ir_write  out  1  instruction register load
- reg_write  out  1  register file write
- reg_dst  out  1  write register: 0 rt, 1 rd
- mem_to_reg  out  1  write data: 0 ALUOut, 1 MDR
- alu_src_a  out  2  srcA: 00 PC, 01 A reg, 10 B reg
- alu_src_b  out  3  srcB: 000 B reg, 001 const 4, 010 sext imm, 011 sext imm<<2, 100 zext imm, 101 shamt zero-extended
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 110 sll
- instr_done  out  1  one-cycle pulse in the last state of every instruction
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode or funct
- state  out  4  current state encoding, for debug

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXEC 6, ALUWB 7, BEQ 8, IMMEX 9, IMMWB 10, JUMP 11. Encodings 12–15 go to FETCH.
- FETCH: iord=0, ir_write=1, alu_src_a=00, alu_src_b=001, alu_control=000, pc_src=00, pc_write=1. Next state is DECODE.
- DECODE: alu_src_a=00, alu_src_b=011, alu_control=000 (branch target into ALUOut). Opcode and funct are captured into internal registers here. Transitions:
  - lw (100011) or sw (101011) → MEMADR
  - R-type (000000) → REXEC
  - beq (000100) → BEQ
  - addi (001000), slti (001010), andi (001100), ori (001101) → IMMEX
  - j (000010) → JUMP
  - anything else → FETCH with illegal_op=1
- MEMADR: alu_src_a=01, alu_src_b=010, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Next state is MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1.
- MEMWR: iord=1, mem_write=1, instr_done=1.
- REXEC: alu_src_a=01, alu_src_b=000. Funct mapping:
  - 100000 → add
  - 100010 → sub
  - 100100 → and
  - 100101 → or
  - 101010 → slt
  - unsupported funct is detected in DECODE: illegal_op pulses and the FSM returns to FETCH
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1.
- BEQ: alu_src_a=01, alu_src_b=000, sub, branch=1, pc_src=01, instr_done=1.
- IMMEX: alu_src_a=01. Mapping:
  - addi: alu_src_b=010, add
  - slti: alu_src_b=010, slt
  - andi: alu_src_b=100, and
  - ori: alu_src_b=100, or
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1.
- JUMP: pc_src=10, pc_write=1, instr_done=1.
- Every completing state returns to FETCH.
- Unlisted outputs are 0 in every state; alu_control defaults to 000.

## Timing
- Moore FSM: state register on the rising clk edge. All outputs are combinational from state and the captured opcode/funct, except pc_en, which also uses same-cycle zero.
- Cycles per instruction, counted from FETCH: lw 5, sw 4, R-type 4, immediate 4, beq 3, j 3, illegal 2.
- rst_n low drives state to FETCH immediately and clears the captured opcode/funct to 0.
- While rst_n is low, pc_en, ir_write, reg_write, mem_write, instr_done and illegal_op are forced to 0. Remaining outputs take their FETCH values.
- The first FETCH executes on the first rising edge after rst_n deasserts.
- Reset mid-instruction abandons the instruction; no write enable asserts afterwards for it.
- Opcode/funct changes after DECODE do not affect the current instruction.

## Configuration
- MC_SLL_EN defined:
  - R-type funct 000000 is legal.
  - REXEC uses alu_src_a=10, alu_src_b=101, alu_control=110.
  - ALUWB follows normally.
- MC_SLL_EN undefined: funct 000000 is illegal (illegal_op pulse in DECODE, return to FETCH), and alu_control never equals 110.

## Test plan
- Reset then release, opcode=0x23 (lw) → state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_done pulses once.
- R-type funct 0x22 (sub) → alu_control=001 in state 6; ALUWB has reg_dst=1; 4 cycles total.
- beq with zero=1 in state 8 → pc_en=1 and pc_src=01; repeat with zero=0 → pc_en=0.
- ori (0x0D) → alu_src_b=100 and alu_control=011 in state 9; reg_write in state 10.
- Opcode 0x3F → illegal_op=1 in DECODE, then FETCH. With MC_SLL_EN undefined, funct 0x00 gives the same result; with it defined, REXEC shows alu_control=110 and alu_src_a=10.
- rst_n asserted during state 3 → state=0 asynchronously; reg_write stays 0; normal fetch resumes after release.

Source files
------------

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control unit for the 32-bit MIPS-subset core.
// Optional feature: define MC_SLL_EN to accept R-type sll (funct 000000).
module mc_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t     cur;
    state_t     dec_next;
    logic [5:0] op_q;
    logic [5:0] fn_q;
    logic       funct_ok;

    // ungated versions of the enables that reset must suppress
    logic pc_write;
    logic branch;
    logic ir_w;
    logic reg_w;
    logic mem_w;
    logic done;
    logic ill;

    // funct codes the R-type path can execute
    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
`ifdef MC_SLL_EN
            FN_SLL: funct_ok = 1'b1;
`endif
            default: funct_ok = 1'b0;
        endcase
    end

    // DECODE dispatch from the live opcode; unknown encodings bounce to FETCH
    always_comb begin
        dec_next = S_FETCH;
        case (opcode)
            OP_LW, OP_SW:                      dec_next = S_MEMADR;
            OP_RTYPE:                          dec_next = funct_ok ? S_REXEC : S_FETCH;
            OP_BEQ:                            dec_next = S_BEQ;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: dec_next = S_IMMEX;
            OP_J:                              dec_next = S_JUMP;
            default:                           dec_next = S_FETCH;
        endcase
    end

    // state register plus opcode/funct capture taken at the end of DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur  <= S_FETCH;
            op_q <= 6'd0;
            fn_q <= 6'd0;
        end else begin
            case (cur)
                S_FETCH:  cur <= S_DECODE;
                S_DECODE: begin
                    op_q <= opcode;
                    fn_q <= funct;
                    cur  <= dec_next;
                end
                S_MEMADR: cur <= (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  cur <= S_MEMWB;
                S_REXEC:  cur <= S_ALUWB;
                S_IMMEX:  cur <= S_IMMWB;
                default:  cur <= S_FETCH;
            endcase
        end
    end

    // Moore output decode from the current state and captured fields
    always_comb begin
        pc_write    = 1'b0;
        branch      = 1'b0;
        ir_w        = 1'b0;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        done        = 1'b0;
        ill         = 1'b0;
        pc_src      = 2'b00;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 3'b000;
        alu_control = ALU_ADD;
        case (cur)
            S_FETCH: begin
                ir_w      = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 3'b001;
            end
            S_DECODE: begin
                alu_src_b = 3'b011;
                ill       = (dec_next == S_FETCH);
            end
            S_MEMADR: begin
                alu_src_a = 2'b01;
                alu_src_b = 3'b010;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                reg_w      = 1'b1;
                mem_to_reg = 1'b1;
                done       = 1'b1;
            end
            S_MEMWR: begin
                iord  = 1'b1;
                mem_w = 1'b1;
                done  = 1'b1;
            end
            S_REXEC: begin
                alu_src_a = 2'b01;
                case (fn_q)
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
`ifdef MC_SLL_EN
                    FN_SLL: begin
                        alu_src_a   = 2'b10;
                        alu_src_b   = 3'b101;
                        alu_control = 3'b110;
                    end
`endif
                    default: alu_control = ALU_ADD;
                endcase
            end
            S_ALUWB: begin
                reg_w   = 1'b1;
                reg_dst = 1'b1;
                done    = 1'b1;
            end
            S_BEQ: begin
                alu_src_a   = 2'b01;
                alu_control = ALU_SUB;
                branch      = 1'b1;
                pc_src      = 2'b01;
                done        = 1'b1;
            end
            S_IMMEX: begin
                alu_src_a = 2'b01;
                case (op_q)
                    OP_SLTI: begin
                        alu_src_b   = 3'b010;
                        alu_control = ALU_SLT;
                    end
                    OP_ANDI: begin
                        alu_src_b   = 3'b100;
                        alu_control = ALU_AND;
                    end
                    OP_ORI: begin
                        alu_src_b   = 3'b100;
                        alu_control = ALU_OR;
                    end
                    default: alu_src_b = 3'b010;
                endcase
            end
            S_IMMWB: begin
                reg_w = 1'b1;
                done  = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    // enables are held off for as long as reset is asserted
    assign pc_en      = rst_n & (pc_write | (branch & zero));
    assign ir_write   = rst_n & ir_w;
    assign reg_write  = rst_n & reg_w;
    assign mem_write  = rst_n & mem_w;
    assign instr_done = rst_n & done;
    assign illegal_op = rst_n & ill;
    assign state      = cur;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: table vectors, reset corner cases and random
// instruction streams against a per-instruction reference model.
module tb_mc_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [2:0] alu_control;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    int passed = 0;
    int total  = 0;

`ifdef MC_SLL_EN
    localparam bit SLL = 1'b1;
`else
    localparam bit SLL = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] state;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] alu_src_a;
        logic [2:0] alu_src_b;
        logic [2:0] alu_control;
        logic       instr_done;
        logic       illegal_op;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         zm;
        int         cycles;
    } vec_t;

    ctl_t act;
    assign act = {state, pc_en, pc_src, iord, mem_write, ir_write,
                  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                  alu_control, instr_done, illegal_op};

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .pc_en(pc_en), .pc_src(pc_src), .iord(iord),
        .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control),
        .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input ctl_t a, input ctl_t e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h expected %h", name, a, e);
    endtask

    task automatic chk_int(input string name, input int a, input int e);
        total++;
        if (a == e) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, a, e);
    endtask

    function automatic logic rfn_ok(input logic [5:0] fn);
        return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
               fn == 6'h25 || fn == 6'h2A || (SLL && fn == 6'h00);
    endfunction

    // instruction class -> visited states (nibble 0 first) and length
    function automatic void plan(input logic [5:0] op, input logic [5:0] fn,
                                 output int len, output logic [31:0] s);
        case (op)
            6'h23: begin s = 32'h43210; len = 5; end
            6'h2B: begin s = 32'h5210;  len = 4; end
            6'h04: begin s = 32'h810;   len = 3; end
            6'h02: begin s = 32'hB10;   len = 3; end
            6'h08, 6'h0A, 6'h0C, 6'h0D: begin s = 32'hA910; len = 4; end
            6'h00: begin
                if (rfn_ok(fn)) begin s = 32'h7610; len = 4; end
                else begin s = 32'h10; len = 2; end
            end
            default: begin s = 32'h10; len = 2; end
        endcase
    endfunction

    // expected control word for one cycle of an instruction
    function automatic ctl_t model(input logic [3:0] st, input logic [5:0] op,
                                   input logic [5:0] fn, input logic z,
                                   input logic rn);
        ctl_t e;
        int   len;
        logic [31:0] s;
        e = '0;
        e.state = st;
        plan(op, fn, len, s);
        case (st)
            4'd0: begin e.ir_write = 1; e.pc_en = 1; e.alu_src_b = 3'd1; end
            4'd1: begin e.alu_src_b = 3'd3; e.illegal_op = (len == 2); end
            4'd2: begin e.alu_src_a = 2'd1; e.alu_src_b = 3'd2; end
            4'd3: e.iord = 1;
            4'd4: begin e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1; end
            4'd5: begin e.iord = 1; e.mem_write = 1; e.instr_done = 1; end
            4'd6: begin
                e.alu_src_a = 2'd1;
                case (fn)
                    6'h22: e.alu_control = 3'd1;
                    6'h24: e.alu_control = 3'd2;
                    6'h25: e.alu_control = 3'd3;
                    6'h2A: e.alu_control = 3'd5;
                    6'h00: begin
                        e.alu_src_a = 2'd2; e.alu_src_b = 3'd5;
                        e.alu_control = 3'd6;
                    end
                    default: e.alu_control = 3'd0;
                endcase
            end
            4'd7: begin e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1; end
            4'd8: begin
                e.alu_src_a = 2'd1; e.alu_control = 3'd1;
                e.pc_src = 2'd1; e.pc_en = z; e.instr_done = 1;
            end
            4'd9: begin
                e.alu_src_a = 2'd1;
                case (op)
                    6'h0A: begin e.alu_src_b = 3'd2; e.alu_control = 3'd5; end
                    6'h0C: begin e.alu_src_b = 3'd4; e.alu_control = 3'd2; end
                    6'h0D: begin e.alu_src_b = 3'd4; e.alu_control = 3'd3; end
                    default: e.alu_src_b = 3'd2;
                endcase
            end
            4'd10: begin e.reg_write = 1; e.instr_done = 1; end
            4'd11: begin e.pc_src = 2'd2; e.pc_en = 1; e.instr_done = 1; end
            default: ;
        endcase
        if (!rn) begin
            e.pc_en = 0; e.ir_write = 0; e.reg_write = 0;
            e.mem_write = 0; e.instr_done = 0; e.illegal_op = 0;
        end
        return e;
    endfunction

    // run one instruction from FETCH; opcode/funct are scrambled after
    // DECODE; n returns how many cycles the DUT took to get back to FETCH
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int zm, input string tag, output int n);
        int          len;
        logic [31:0] s;
        logic [3:0]  st;
        plan(op, fn, len, s);
        n = 0;
        do begin
            @(negedge clk);
            if (n == 0) begin
                opcode = op;
                funct  = fn;
            end else if (n >= 2) begin
                opcode = 6'($urandom);
                funct  = 6'($urandom);
            end
            zero = (zm == 2) ? 1'($urandom) : zm[0];
            #1;
            st = (n < len) ? s[n*4 +: 4] : 4'd0;
            chk($sformatf("%s op=%h fn=%h cyc%0d", tag, op, fn, n), act,
                model(st, op, fn, zero, 1'b1));
            n++;
            @(posedge clk);
            #1;
        end while (state != 4'd0 && n < 8);
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] ops [10];
        int k;
        ops = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04,
                6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h02};
        k = $urandom_range(0, 11);
        return (k < 10) ? ops[k] : 6'($urandom);
    endfunction

    function automatic logic [5:0] pick_fn();
        logic [5:0] fns [6];
        int k;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        k = $urandom_range(0, 7);
        return (k < 6) ? fns[k] : 6'($urandom);
    endfunction

    initial begin
        vec_t vecs [18];
        int   n;
        int   len;
        logic [31:0] s;
        logic [5:0]  op;
        logic [5:0]  fn;

        vecs = '{
            '{6'h23, 6'h20, 0, 5}, '{6'h2B, 6'h11, 0, 4},
            '{6'h00, 6'h20, 0, 4}, '{6'h00, 6'h22, 0, 4},
            '{6'h00, 6'h24, 1, 4}, '{6'h00, 6'h25, 0, 4},
            '{6'h00, 6'h2A, 0, 4}, '{6'h04, 6'h00, 1, 3},
            '{6'h04, 6'h00, 0, 3}, '{6'h08, 6'h00, 0, 4},
            '{6'h0A, 6'h00, 0, 4}, '{6'h0C, 6'h00, 0, 4},
            '{6'h0D, 6'h3F, 0, 4}, '{6'h02, 6'h00, 1, 3},
            '{6'h3F, 6'h20, 0, 2}, '{6'h00, 6'h00, 0, SLL ? 4 : 2},
            '{6'h00, 6'h3F, 0, 2}, '{6'h00, 6'h21, 0, 2}
        };

        rst_n = 0; opcode = 0; funct = 0; zero = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 chk("reset", act, model(4'd0, 6'h00, 6'h00, 1'b0, 1'b0));
        opcode = 6'h3F; zero = 1;
        #1 chk("reset_gated", act, model(4'd0, 6'h3F, 6'h00, 1'b1, 1'b0));
        @(posedge clk);
        #1 rst_n = 1;

        for (int i = 0; i < 18; i++) begin
            run_instr(vecs[i].op, vecs[i].fn, vecs[i].zm, "vec", n);
            chk_int($sformatf("cpi vec%0d", i), n, vecs[i].cycles);
        end

        // reset while lw sits in MEMRD
        @(negedge clk); opcode = 6'h23; funct = 0; zero = 0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1 chk("pre_rst", act, model(4'd3, 6'h23, 6'h00, 1'b0, 1'b1));
        #1 rst_n = 0;
        #1 chk("async_rst", act, model(4'd0, 6'h23, 6'h00, 1'b0, 1'b0));
        @(posedge clk);
        #1 chk("rst_hold", act, model(4'd0, 6'h23, 6'h00, 1'b0, 1'b0));
        rst_n = 1;
        run_instr(6'h23, 6'h00, 0, "post_rst", n);
        chk_int("cpi post_rst", n, 5);

        repeat (200) begin
            op = pick_op();
            fn = pick_fn();
            plan(op, fn, len, s);
            run_instr(op, fn, 2, "rand", n);
            chk_int($sformatf("cpi rand op=%h fn=%h", op, fn), n, len);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
